cpu_io_serdes: RTL and testbench

CPU-side serial link engine that drives the `tx_fetch`, `tx_jump` and `tx_pins` lines and decodes the returned `rx_pins` stream. It is the last stage before the chip pin registers. It serializes 16-bit words from the CPU core into IO_BITS-wide chunks and deserializes words returned by the external memory. It also tracks how many fetch requests are still awaiting a reply.

---
 rtl/cpu_io_serdes.sv | 210 +++++++++++++++++++++
 tb/tb_cpu_io_serdes.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_io_serdes.sv
// CPU-side serial link: serializes TX words into IO_BITS chunks behind a start marker,
// deserializes RX words into a one-entry buffer, and tracks outstanding fetch credits.
//
//   state      | meaning
//   TX_IDLE    | no frame; tx_pins/tx_jump low, ready for a word
//   TX_START   | start marker (tx_pins = 1) on the wire
//   TX_DATA    | chunk tx_k_q on the wire, LSB chunk first
//   RX_IDLE    | hunting for a start marker on rx_pins
//   RX_RECV    | shifting in chunk rx_k_q
module cpu_io_serdes #(
    parameter int IO_BITS   = 2,
    parameter int WORD_BITS = 16,
    parameter int MAX_FETCH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_BITS-1:0] in_data,
    input  logic                 in_jump,
    input  logic                 fetch_req,
    output logic                 fetch_ready,
    output logic [IO_BITS-1:0]   tx_pins,
    output logic                 tx_jump,
    output logic                 tx_fetch,
    input  logic [IO_BITS-1:0]   rx_pins,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_BITS-1:0] out_data,
    output logic                 overrun
);

    localparam int N  = WORD_BITS / IO_BITS;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_FETCH + 1);

    localparam logic [KW-1:0]      K_LAST     = KW'(N - 1);
    localparam logic [IO_BITS-1:0] MARKER     = IO_BITS'(1);
    localparam logic [CW-1:0]      CREDIT_MAX = CW'(MAX_FETCH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA} tx_state_t;
    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;

    tx_state_t              tx_state_q, tx_state_d;
    logic [KW-1:0]          tx_k_q, tx_k_d;
    logic [WORD_BITS-1:0]   tx_sh_q, tx_sh_d;
    logic                   tx_jump_lat_q, tx_jump_lat_d;
    logic [IO_BITS-1:0]     tx_pins_q, tx_pins_d;
    logic                   tx_jump_q, tx_jump_d;
    logic                   tx_fetch_q, tx_fetch_d;
    logic [CW-1:0]          credits_q, credits_d;
    rx_state_t              rx_state_q, rx_state_d;
    logic [KW-1:0]          rx_k_q, rx_k_d;
    logic [WORD_BITS-1:0]   rx_sh_q, rx_sh_d;
    logic                   out_valid_q, out_valid_d;
    logic [WORD_BITS-1:0]   out_data_q, out_data_d;
    logic                   overrun_q, overrun_d;

    logic                   tx_last;
    logic                   tx_hs;
    logic                   fetch_acc;
    logic                   rx_done;
    logic [WORD_BITS-1:0]   rx_word;

    // Readies are gated by rst_n so nothing is accepted while reset is held.
    assign tx_last     = (tx_state_q == TX_DATA) && (tx_k_q == K_LAST);
    assign in_ready    = rst_n && ((tx_state_q == TX_IDLE) || tx_last);
    assign tx_hs       = in_valid && in_ready;
    assign fetch_ready = rst_n && (credits_q < CREDIT_MAX);
    assign fetch_acc   = fetch_req && fetch_ready;

    always_comb begin
        tx_state_d    = tx_state_q;
        tx_k_d        = tx_k_q;
        tx_sh_d       = tx_sh_q;
        tx_jump_lat_d = tx_jump_lat_q;
        tx_pins_d     = '0;
        tx_jump_d     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_hs) begin
                    tx_state_d    = TX_START;
                    tx_sh_d       = in_data;
                    tx_jump_lat_d = in_jump;
                end
            end
            TX_START: begin
                tx_state_d = TX_DATA;
                tx_k_d     = '0;
                tx_pins_d  = tx_sh_q[IO_BITS-1:0];
                tx_sh_d    = tx_sh_q >> IO_BITS;
            end
            TX_DATA: begin
                if (tx_k_q == K_LAST) begin
                    if (tx_hs) begin
                        tx_state_d    = TX_START;
                        tx_sh_d       = in_data;
                        tx_jump_lat_d = in_jump;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_k_d    = tx_k_q + KW'(1);
                    tx_pins_d = tx_sh_q[IO_BITS-1:0];
                    tx_sh_d   = tx_sh_q >> IO_BITS;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_state_d == TX_START) begin
            tx_pins_d = MARKER;
        end
        if (tx_state_d != TX_IDLE) begin
            tx_jump_d = tx_jump_lat_d;
        end
    end

    assign rx_done = (rx_state_q == RX_RECV) && (rx_k_q == K_LAST);
    assign rx_word = {rx_pins, rx_sh_q[WORD_BITS-1:IO_BITS]};

    always_comb begin
        rx_state_d = rx_state_q;
        rx_k_d     = rx_k_q;
        rx_sh_d    = rx_sh_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_pins == MARKER) begin
                    rx_state_d = RX_RECV;
                    rx_k_d     = '0;
                end
            end
            RX_RECV: begin
                rx_sh_d = rx_word;
                if (rx_k_q == K_LAST) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_k_d = rx_k_q + KW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // A buffer drained on the completion edge counts as free.
    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        overrun_d   = overrun_q;
        if (rx_done) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_data_d  = rx_word;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_comb begin
        tx_fetch_d = fetch_acc;
        credits_d  = credits_q;
        if (fetch_acc && !rx_done) begin
            credits_d = credits_q + CW'(1);
        end else if (!fetch_acc && rx_done && (credits_q != '0)) begin
            credits_d = credits_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q    <= TX_IDLE;
            tx_k_q        <= '0;
            tx_sh_q       <= '0;
            tx_jump_lat_q <= 1'b0;
            tx_pins_q     <= '0;
            tx_jump_q     <= 1'b0;
            tx_fetch_q    <= 1'b0;
            credits_q     <= '0;
            rx_state_q    <= RX_IDLE;
            rx_k_q        <= '0;
            rx_sh_q       <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            overrun_q     <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_k_q        <= tx_k_d;
            tx_sh_q       <= tx_sh_d;
            tx_jump_lat_q <= tx_jump_lat_d;
            tx_pins_q     <= tx_pins_d;
            tx_jump_q     <= tx_jump_d;
            tx_fetch_q    <= tx_fetch_d;
            credits_q     <= credits_d;
            rx_state_q    <= rx_state_d;
            rx_k_q        <= rx_k_d;
            rx_sh_q       <= rx_sh_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            overrun_q     <= overrun_d;
        end
    end

    assign tx_pins   = tx_pins_q;
    assign tx_jump   = tx_jump_q;
    assign tx_fetch  = tx_fetch_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_cpu_io_serdes.sv
// Self-checking bench for cpu_io_serdes: TX vector table, hand-written multi-cycle
// sequences, and queue scoreboards for the TX pin stream and delivered RX words.
module tb_cpu_io_serdes;

    localparam int IO_BITS   = 2;
    localparam int WORD_BITS = 16;
    localparam int MAX_FETCH = 3;
    localparam int N         = WORD_BITS / IO_BITS;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_BITS-1:0] in_data;
    logic                 in_jump;
    logic                 fetch_req;
    logic                 fetch_ready;
    logic [IO_BITS-1:0]   tx_pins;
    logic                 tx_jump;
    logic                 tx_fetch;
    logic [IO_BITS-1:0]   rx_pins;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_BITS-1:0] out_data;
    logic                 overrun;

    cpu_io_serdes #(
        .IO_BITS  (IO_BITS),
        .WORD_BITS(WORD_BITS),
        .MAX_FETCH(MAX_FETCH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_jump    (in_jump),
        .fetch_req  (fetch_req),
        .fetch_ready(fetch_ready),
        .tx_pins    (tx_pins),
        .tx_jump    (tx_jump),
        .tx_fetch   (tx_fetch),
        .rx_pins    (rx_pins),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] word;
        logic        jump;
        logic [1:0]  c0;
        logic [1:0]  c7;
    } tx_vec_t;

    typedef struct {
        logic [1:0] pins;
        logic       jump;
    } tx_exp_t;

    tx_vec_t     vecs [6];
    tx_exp_t     txq [$];
    logic [15:0] rxq [$];
    logic        exp_hs = 1'b0;
    logic        pre_done_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Marker, then chunks LSB first; optional drain / fetch on the completion edge.
    task automatic send_rx(input logic [15:0] w, input logic keep,
                           input logic drain_last, input logic fetch_last);
        rx_pins = 2'd1;
        step(1);
        for (int k = 0; k < N; k++) begin
            rx_pins = w[k*2 +: 2];
            if (k == N - 1) begin
                pre_done_valid = out_valid;
                if (drain_last) out_ready = 1'b1;
                if (fetch_last) fetch_req = 1'b1;
            end
            step(1);
        end
        rx_pins   = 2'd0;
        fetch_req = 1'b0;
        if (keep) rxq.push_back(w);
    endtask

    // Scoreboard monitor, mid-cycle away from the active edge.
    always @(negedge clk) begin
        tx_exp_t e;
        if (!rst_n) begin
            txq.delete();
        end else begin
            if (txq.size() > 0) begin
                e = txq.pop_front();
            end else begin
                e.pins = 2'd0;
                e.jump = 1'b0;
            end
            check("tx_pins stream", 32'(tx_pins), 32'(e.pins));
            check("tx_jump stream", 32'(tx_jump), 32'(e.jump));
            if (exp_hs) begin
                check("in_ready at handshake", 32'(in_ready), 32'd1);
                e.pins = 2'd1;
                e.jump = in_jump;
                txq.push_back(e);
                for (int k = 0; k < N; k++) begin
                    e.pins = in_data[k*2 +: 2];
                    txq.push_back(e);
                end
            end
            if (out_valid && out_ready) begin
                if (rxq.size() == 0) check("rx word not expected", 32'(out_valid), 32'd0);
                else check("rx word", 32'(out_data), 32'(rxq.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] tput [3];
        vecs[0] = '{16'hA5C3, 1'b0, 2'd3, 2'd2};
        vecs[1] = '{16'h1234, 1'b1, 2'd0, 2'd0};
        vecs[2] = '{16'hFFFF, 1'b0, 2'd3, 2'd3};
        vecs[3] = '{16'h0001, 1'b1, 2'd1, 2'd0};
        vecs[4] = '{16'h8000, 1'b0, 2'd0, 2'd2};
        vecs[5] = '{16'h4002, 1'b1, 2'd2, 2'd1};
        tput[0] = 16'h1111;
        tput[1] = 16'hABCD;
        tput[2] = 16'h5555;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_jump   = 1'b0;
        fetch_req = 1'b0;
        rx_pins   = '0;
        out_ready = 1'b1;
        #1;
        check("reset tx_pins", 32'(tx_pins), 32'd0);
        check("reset tx_jump", 32'(tx_jump), 32'd0);
        check("reset tx_fetch", 32'(tx_fetch), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset fetch_ready", 32'(fetch_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("in_ready after release", 32'(in_ready), 32'd1);
        check("fetch_ready after release", 32'(fetch_ready), 32'd1);
        step(1);

        // Isolated TX frames
        for (int i = 0; i < 6; i++) begin
            check("tx idle ready", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = vecs[i].word;
            in_jump  = vecs[i].jump;
            exp_hs   = 1'b1;
            step(1);
            in_valid = 1'b0;
            exp_hs   = 1'b0;
            check("tx start marker", 32'(tx_pins), 32'd1);
            check("tx start jump", 32'(tx_jump), 32'(vecs[i].jump));
            check("tx busy not ready", 32'(in_ready), 32'd0);
            step(1);
            check("tx chunk0", 32'(tx_pins), 32'(vecs[i].c0));
            step(7);
            check("tx chunk7", 32'(tx_pins), 32'(vecs[i].c7));
            check("tx ready in last chunk", 32'(in_ready), 32'd1);
            check("tx jump last chunk", 32'(tx_jump), 32'(vecs[i].jump));
            step(1);
            check("tx idle after frame", 32'(tx_pins), 32'd0);
        end

        // Back-to-back jump then data frame with in_valid held
        in_valid = 1'b1;
        in_data  = 16'h1234;
        in_jump  = 1'b1;
        exp_hs   = 1'b1;
        step(1);
        exp_hs  = 1'b0;
        in_data = 16'hFFFF;
        in_jump = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("b2b jump frame tx_jump", 32'(tx_jump), 32'd1);
            if (i == 0) check("b2b busy", 32'(in_ready), 32'd0);
            if (i == 8) begin
                check("b2b ready last chunk", 32'(in_ready), 32'd1);
                exp_hs = 1'b1;
            end
            step(1);
        end
        exp_hs   = 1'b0;
        in_valid = 1'b0;
        check("b2b second start", 32'(tx_pins), 32'd1);
        check("b2b second jump", 32'(tx_jump), 32'd0);
        step(10);

        // Fetch credits
        fetch_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            check("fetch pulse", 32'(tx_fetch), 32'(i <= 3));
            check("fetch_ready credits", 32'(fetch_ready), 32'(i < 3));
        end
        fetch_req = 1'b0;
        step(1);
        check("fetch no pulse when full", 32'(tx_fetch), 32'd0);
        send_rx(16'h0F0F, 1'b1, 1'b0, 1'b0);
        check("fetch_ready after reply", 32'(fetch_ready), 32'd1);
        send_rx(16'hC3C3, 1'b1, 1'b0, 1'b1);
        check("simul fetch pulse", 32'(tx_fetch), 32'd1);
        check("simul credits unchanged", 32'(fetch_ready), 32'd1);
        fetch_req = 1'b1;
        step(1);
        fetch_req = 1'b0;
        check("credits full again", 32'(fetch_ready), 32'd0);
        step(2);

        // RX single word, held until consumed
        out_ready = 1'b0;
        check("rx idle valid", 32'(out_valid), 32'd0);
        send_rx(16'hBEEF, 1'b1, 1'b0, 1'b0);
        check("rx valid not early", 32'(pre_done_valid), 32'd0);
        check("rx valid rise", 32'(out_valid), 32'd1);
        check("rx data", 32'(out_data), 32'h0000BEEF);
        step(3);
        check("rx hold valid", 32'(out_valid), 32'd1);
        check("rx hold data", 32'(out_data), 32'h0000BEEF);
        out_ready = 1'b1;
        step(1);
        check("rx drained", 32'(out_valid), 32'd0);

        // Back-to-back RX at full rate
        for (int i = 0; i < 3; i++) begin
            send_rx(tput[i], 1'b1, 1'b0, 1'b0);
            check("tput valid", 32'(out_valid), 32'd1);
            check("tput data", 32'(out_data), 32'(tput[i]));
        end
        out_ready = 1'b0;
        send_rx(16'h7777, 1'b1, 1'b1, 1'b0);
        check("drain-same-edge valid", 32'(out_valid), 32'd1);
        check("drain-same-edge data", 32'(out_data), 32'h00007777);
        check("no overrun at rate", 32'(overrun), 32'd0);
        step(1);
        check("drain-same-edge consumed", 32'(out_valid), 32'd0);

        // Overrun
        out_ready = 1'b0;
        send_rx(16'h1357, 1'b1, 1'b0, 1'b0);
        check("overrun clear first", 32'(overrun), 32'd0);
        send_rx(16'h2468, 1'b0, 1'b0, 1'b0);
        check("overrun set", 32'(overrun), 32'd1);
        check("overrun keeps first", 32'(out_data), 32'h00001357);
        out_ready = 1'b1;
        step(1);
        check("overrun drained", 32'(out_valid), 32'd0);
        step(3);
        check("overrun sticky", 32'(overrun), 32'd1);

        // Reset during DATA(3)
        in_valid = 1'b1;
        in_data  = 16'h5A5A;
        in_jump  = 1'b1;
        exp_hs   = 1'b1;
        step(1);
        in_valid = 1'b0;
        exp_hs   = 1'b0;
        step(4);
        check("pre-reset chunk3", 32'(tx_pins), 32'd1);
        check("pre-reset jump", 32'(tx_jump), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset tx_pins", 32'(tx_pins), 32'd0);
        check("mid reset tx_jump", 32'(tx_jump), 32'd0);
        check("mid reset in_ready", 32'(in_ready), 32'd0);
        check("mid reset overrun", 32'(overrun), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("post reset in_ready", 32'(in_ready), 32'd1);
        check("post reset tx_pins", 32'(tx_pins), 32'd0);
        in_valid = 1'b1;
        in_data  = 16'h0003;
        in_jump  = 1'b0;
        exp_hs   = 1'b1;
        step(1);
        in_valid = 1'b0;
        exp_hs   = 1'b0;
        check("post reset start", 32'(tx_pins), 32'd1);
        check("post reset start jump", 32'(tx_jump), 32'd0);
        step(1);
        check("post reset chunk0", 32'(tx_pins), 32'd3);
        step(9);
        check("post reset idle", 32'(tx_pins), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
